// File: rtl/types.sv
// ============================================================================
// types : shared widths, selects and pipeline bundles for the core
// Revision 1.0
// ============================================================================
`default_nettype none

package types;

  typedef logic [31:0] u32_t;
  typedef logic [4:0]  regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  // 2'b11 is not named; consumers treat it as SEL_ZERO.
  typedef enum logic [1:0] {
    SEL_ZERO   = 2'b00,
    SEL_IA_IMM = 2'b01,
    SEL_REG    = 2'b10
  } sel_t;

  typedef enum logic [1:0] {
    FW_SEL_ID_EX  = 2'b00,
    FW_SEL_EX_MEM = 2'b01,
    FW_SEL_MEM_WB = 2'b10
  } fw_sel_t;

  typedef struct packed {
    u32_t       ia_plus_4;
    u32_t       imm;
    logic [1:0] shift;
    sel_t       a_sel;
    sel_t       b_sel;
    regaddr_t   ra_addr;
    regaddr_t   rb_addr;
    regaddr_t   rd_addr;
    u32_t       ra_data;
    u32_t       rb_data;
  } ex_params_t;

  typedef struct packed {
    u32_t     ia_plus_4;
    u32_t     result;
    u32_t     store_data;
    regaddr_t rd_addr;
  } mem_params_t;

endpackage

`default_nettype wire

// File: rtl/fw_unit.sv
// ============================================================================
// fw_unit : operand forwarding select for one register source
// Revision 1.0
// ============================================================================
`default_nettype none

module fw_unit
  import types::*;
(
  input  regaddr_t addr,
  input  logic     exmem_valid,
  input  regaddr_t exmem_rd_addr,
  input  logic     wb_valid,
  input  regaddr_t wb_rd_addr,
  output fw_sel_t  sel
);

  // r0 is hard-wired, so it never takes a forwarded value.
  always_comb begin
    sel = FW_SEL_ID_EX;
    if (addr != REG_ZERO) begin
      if (exmem_valid && (exmem_rd_addr == addr)) begin
        sel = FW_SEL_EX_MEM;
      end else if (wb_valid && (wb_rd_addr == addr)) begin
        sel = FW_SEL_MEM_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : ID/EX register, operand forwarding, adder and EX/MEM register
// Revision 1.0
// ============================================================================
`default_nettype none

module ex_stage
  import types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  ex_params_t  in_params,
  input  logic        flush,
  input  logic        wb_valid,
  input  regaddr_t    wb_rd_addr,
  input  u32_t        wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output mem_params_t out_params
);

  logic       idex_valid;
  ex_params_t idex;
  logic       advance;
  fw_sel_t    ra_sel;
  fw_sel_t    rb_sel;
  u32_t       ra_fwd;
  u32_t       rb_fwd;
  u32_t       op_a;
  u32_t       op_b;
  u32_t       result;

  assign advance  = idex_valid && (!out_valid || out_ready);
  assign in_ready = !idex_valid || advance;

  fw_unit u_fw_ra (
    .addr          (idex.ra_addr),
    .exmem_valid   (out_valid),
    .exmem_rd_addr (out_params.rd_addr),
    .wb_valid      (wb_valid),
    .wb_rd_addr    (wb_rd_addr),
    .sel           (ra_sel)
  );

  fw_unit u_fw_rb (
    .addr          (idex.rb_addr),
    .exmem_valid   (out_valid),
    .exmem_rd_addr (out_params.rd_addr),
    .wb_valid      (wb_valid),
    .wb_rd_addr    (wb_rd_addr),
    .sel           (rb_sel)
  );

  always_comb begin
    ra_fwd = idex.ra_data;
    rb_fwd = idex.rb_data;
    case (ra_sel)
      FW_SEL_EX_MEM: ra_fwd = out_params.result;
      FW_SEL_MEM_WB: ra_fwd = wb_data;
      default:       ra_fwd = idex.ra_data;
    endcase
    case (rb_sel)
      FW_SEL_EX_MEM: rb_fwd = out_params.result;
      FW_SEL_MEM_WB: rb_fwd = wb_data;
      default:       rb_fwd = idex.rb_data;
    endcase
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (idex.a_sel)
      SEL_IA_IMM: op_a = idex.ia_plus_4;
      SEL_REG:    op_a = ra_fwd;
      default:    op_a = '0;
    endcase
    case (idex.b_sel)
      SEL_IA_IMM: op_b = idex.imm << {idex.shift, 3'b000};
      SEL_REG:    op_b = rb_fwd;
      default:    op_b = '0;
    endcase
  end

  assign result = op_a + op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_valid <= 1'b0;
      idex       <= '0;
      out_valid  <= 1'b0;
      out_params <= '0;
    end else if (flush) begin
      idex_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (advance) begin
        out_params.ia_plus_4  <= idex.ia_plus_4;
        out_params.result     <= result;
        out_params.store_data <= rb_fwd;
        out_params.rd_addr    <= idex.rd_addr;
        out_valid             <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_valid && in_ready) begin
        idex       <= in_params;
        idex_valid <= 1'b1;
      end else if (advance) begin
        idex_valid <= 1'b0;
      end else if (idex_valid) begin
        // Stalled: capture a retiring writer before MEM/WB moves on.
        if (ra_sel == FW_SEL_MEM_WB) idex.ra_data <= wb_data;
        if (rb_sel == FW_SEL_MEM_WB) idex.rb_data <= wb_data;
      end
    end
  end

endmodule

`default_nettype wire
